// File: rtl/ts_ddr_arbiter.sv
// ts_ddr_arbiter: shares one DDR3 Avalon-MM port between TS record and replay.
// Define TS_DDR_ARB_STATS_EN to build the WR_COUNT/RD_COUNT accept counters.
module ts_ddr_arbiter #(
  parameter int ADDR_W          = 24,
  parameter int DATA_W          = 32,
  parameter int QUANTUM         = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              SYS_CLOCK,
  input  logic              SYS_RESET,
  input  logic              WR_REQ,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic [3:0]        WR_BE,
  output logic              WR_ACK,
  input  logic              RD_REQ,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_ACK,
  output logic              RD_VALID,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [ADDR_W-1:0] ddr_address,
  output logic              ddr_write,
  output logic [DATA_W-1:0] ddr_writedata,
  output logic [3:0]        ddr_byteenable,
  output logic              ddr_read,
  input  logic              ddr_waitrequest,
  input  logic              ddr_readdatavalid,
  input  logic [DATA_W-1:0] ddr_readdata,
  output logic [1:0]        OWNER,
  output logic [31:0]       WR_COUNT,
  output logic [31:0]       RD_COUNT
);

  localparam int QW = $clog2(QUANTUM + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [QW-1:0] QMAX = QW'(QUANTUM);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_OWN = 2'd1,
    RD_OWN = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d, qcnt_inc;
  logic [OW-1:0] out_q, out_d;
  logic          cap_ok, rd_blk, q_exp;
  logic          stall, sw_ok;

  assign cap_ok = (out_q < OMAX);
  assign rd_blk = RD_REQ & ~cap_ok;
  assign stall  = (ddr_write | ddr_read) & ddr_waitrequest;
  assign sw_ok  = ~stall;

  always_ff @(posedge SYS_CLOCK) begin
    if (SYS_RESET) begin
      state_q <= IDLE;
      qcnt_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      out_q   <= out_d;
    end
  end

  // Stray read data with nothing in flight must not wrap the count.
  always_comb begin
    out_d = out_q;
    if (RD_ACK & ~ddr_readdatavalid)
      out_d = out_q + 1'b1;
    else if (~RD_ACK & ddr_readdatavalid & (out_q != '0))
      out_d = out_q - 1'b1;
  end

  // Expiry includes the current acceptance so a grant yields
  // right after its QUANTUM-th transfer.
  always_comb begin
    qcnt_inc = qcnt_q;
    if ((WR_ACK | RD_ACK) & (qcnt_q != QMAX))
      qcnt_inc = qcnt_q + 1'b1;
  end

  assign q_exp  = (qcnt_inc == QMAX);
  assign qcnt_d = (state_d != state_q) ? '0 : qcnt_inc;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (WR_REQ)
          state_d = WR_OWN;
        else if (RD_REQ)
          state_d = RD_OWN;
      end
      WR_OWN: begin
        if (sw_ok) begin
          if (RD_REQ & (~WR_REQ | q_exp))
            state_d = RD_OWN;
          else if (~WR_REQ)
            state_d = IDLE;
        end
      end
      RD_OWN: begin
        if (sw_ok) begin
          if (WR_REQ & (~RD_REQ | q_exp | rd_blk))
            state_d = (out_d == '0) ? WR_OWN : DRAIN;
          else if (~RD_REQ & ~WR_REQ)
            state_d = IDLE;
        end
      end
      DRAIN: begin
        if (out_d == '0)
          state_d = WR_OWN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are gated by reset so they drop in the reset cycle.
  always_comb begin
    ddr_write   = 1'b0;
    ddr_read    = 1'b0;
    ddr_address = WR_ADDR;
    if (!SYS_RESET) begin
      ddr_write = WR_REQ & (state_q == WR_OWN);
      ddr_read  = RD_REQ & (state_q == RD_OWN) & cap_ok;
    end
    if (state_q == RD_OWN)
      ddr_address = RD_ADDR;
  end

  assign ddr_writedata  = WR_DATA;
  assign ddr_byteenable = WR_BE;
  assign WR_ACK   = ddr_write & ~ddr_waitrequest;
  assign RD_ACK   = ddr_read & ~ddr_waitrequest;
  assign RD_VALID = ddr_readdatavalid;
  assign RD_DATA  = ddr_readdata;
  assign OWNER    = SYS_RESET ? 2'd0 : state_q;

`ifdef TS_DDR_ARB_STATS_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (WR_ACK & (wr_cnt_q != 32'hFFFF_FFFF))
      wr_cnt_d = wr_cnt_q + 32'd1;
    if (RD_ACK & (rd_cnt_q != 32'hFFFF_FFFF))
      rd_cnt_d = rd_cnt_q + 32'd1;
  end

  always_ff @(posedge SYS_CLOCK) begin
    if (SYS_RESET) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign WR_COUNT = wr_cnt_q;
  assign RD_COUNT = rd_cnt_q;
`else
  assign WR_COUNT = '0;
  assign RD_COUNT = '0;
`endif

endmodule

// File: tb/tb_ts_ddr_arbiter.sv
// tb_ts_ddr_arbiter: directed arbitration cases plus a randomized
// scoreboard run against a DDR responder model.
module tb_ts_ddr_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int QN = 16;
  localparam int MO = 8;
  localparam int NW = 100;
  localparam int NR = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          SYS_RESET = 1'b1;
  logic          WR_REQ = 1'b0;
  logic [AW-1:0] WR_ADDR = '0;
  logic [DW-1:0] WR_DATA = '0;
  logic [3:0]    WR_BE = '0;
  logic          RD_REQ = 1'b0;
  logic [AW-1:0] RD_ADDR = '0;
  logic          WR_ACK, RD_ACK, RD_VALID;
  logic [DW-1:0] RD_DATA;
  logic [AW-1:0] ddr_address;
  logic          ddr_write, ddr_read;
  logic [DW-1:0] ddr_writedata;
  logic [3:0]    ddr_byteenable;
  logic          ddr_waitrequest, ddr_readdatavalid;
  logic [DW-1:0] ddr_readdata;
  logic [1:0]    OWNER;
  logic [31:0]   WR_COUNT, RD_COUNT;

  logic          auto_ddr = 1'b0;
  logic          m_wait = 1'b0, m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          a_wait = 1'b0, a_valid = 1'b0;
  logic [DW-1:0] a_data = '0;

  assign ddr_waitrequest   = auto_ddr ? a_wait : m_wait;
  assign ddr_readdatavalid = auto_ddr ? a_valid : m_valid;
  assign ddr_readdata      = auto_ddr ? a_data : m_data;

  ts_ddr_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .QUANTUM(QN), .MAX_OUTSTANDING(MO)
  ) dut (
    .SYS_CLOCK(clk),
    .SYS_RESET(SYS_RESET),
    .WR_REQ(WR_REQ),
    .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA),
    .WR_BE(WR_BE),
    .WR_ACK(WR_ACK),
    .RD_REQ(RD_REQ),
    .RD_ADDR(RD_ADDR),
    .RD_ACK(RD_ACK),
    .RD_VALID(RD_VALID),
    .RD_DATA(RD_DATA),
    .ddr_address(ddr_address),
    .ddr_write(ddr_write),
    .ddr_writedata(ddr_writedata),
    .ddr_byteenable(ddr_byteenable),
    .ddr_read(ddr_read),
    .ddr_waitrequest(ddr_waitrequest),
    .ddr_readdatavalid(ddr_readdatavalid),
    .ddr_readdata(ddr_readdata),
    .OWNER(OWNER),
    .WR_COUNT(WR_COUNT),
    .RD_COUNT(RD_COUNT)
  );

  int tests = 0;
  int errors = 0;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rdat(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h5A, a} ^ 32'h1357_9BDF;
  endfunction

  logic [59:0]   wq[$];
  logic [AW-1:0] rcq[$];
  logic [DW-1:0] rdq[$];

  // DDR responder: random stalls, random read latency.
  int            cyc = 0;
  logic [DW-1:0] pend_d[$];
  int            pend_t[$];

  always @(negedge clk) begin
    if (auto_ddr && ddr_read && !ddr_waitrequest) begin
      pend_d.push_back(rdat(ddr_address));
      pend_t.push_back(cyc + $urandom_range(1, 5));
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    a_wait  = ($urandom_range(0, 3) == 0);
    a_valid = 1'b0;
    if (pend_d.size() != 0 && pend_t[0] <= cyc &&
        $urandom_range(0, 3) != 0) begin
      a_valid = 1'b1;
      a_data  = pend_d.pop_front();
      void'(pend_t.pop_front());
    end
  end

  // Monitor / scoreboard.
  logic        mon_en = 1'b0;
  logic        wacc, racc;
  logic        p_ws = 1'b0, p_rs = 1'b0;
  logic [63:0] p_w = '0, p_r = '0;
  int          out_m = 0, wrun = 0, rrun = 0;

  always @(negedge clk) begin
    if (mon_en && !SYS_RESET) begin
      wacc = ddr_write && !ddr_waitrequest;
      racc = ddr_read && !ddr_waitrequest;
      check("excl", {63'd0, ddr_write & ddr_read}, 64'd0);
      check("wr_ack", {63'd0, WR_ACK}, {63'd0, wacc});
      check("rd_ack", {63'd0, RD_ACK}, {63'd0, racc});
      if (p_ws)
        check("wr_hold", {3'd0, ddr_write, ddr_address,
              ddr_writedata, ddr_byteenable}, p_w);
      if (p_rs)
        check("rd_hold", {39'd0, ddr_read, ddr_address}, p_r);
      p_ws = ddr_write && ddr_waitrequest;
      p_w  = {3'd0, ddr_write, ddr_address,
              ddr_writedata, ddr_byteenable};
      p_rs = ddr_read && ddr_waitrequest;
      p_r  = {39'd0, ddr_read, ddr_address};
      if (wacc) begin
        if (wq.size() == 0)
          check("wr_extra", 64'd1, 64'd0);
        else
          check("wr_cmd", {4'd0, ddr_address, ddr_writedata,
                ddr_byteenable}, {4'd0, wq.pop_front()});
      end
      if (racc) begin
        if (rcq.size() == 0)
          check("rd_extra", 64'd1, 64'd0);
        else
          check("rd_cmd", {40'd0, ddr_address},
                {40'd0, rcq.pop_front()});
      end
      if (RD_VALID) begin
        if (rdq.size() == 0)
          check("rd_data_extra", 64'd1, 64'd0);
        else
          check("rd_data", {32'd0, RD_DATA},
                {32'd0, rdq.pop_front()});
      end
      if (ddr_read)
        check("rd_cap", {63'd0, out_m < MO}, 64'd1);
      if (!RD_REQ || racc || out_m >= MO) wrun = 0;
      else if (wacc) wrun++;
      if (!WR_REQ || wacc) rrun = 0;
      else if (racc) rrun++;
      if (wacc)
        check("wr_quantum", {63'd0, wrun <= QN}, 64'd1);
      if (racc)
        check("rd_quantum", {63'd0, rrun <= QN}, 64'd1);
      if (racc && !RD_VALID) out_m++;
      else if (!racc && RD_VALID && out_m > 0) out_m--;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    SYS_RESET = 1'b1;
    WR_REQ = 1'b0;
    RD_REQ = 1'b0;
    m_wait = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    check("rst_strobes", {59'd0, OWNER, ddr_write,
          ddr_read, WR_ACK, RD_ACK}, 64'd0);
    step();
    @(negedge clk);
    check("rst_stats", {WR_COUNT, RD_COUNT}, 64'd0);
    step();
    SYS_RESET = 1'b0;
  endtask

  task automatic count_rd(input int ncyc, output int n);
    n = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (RD_ACK) n++;
      step();
    end
  endtask

  task automatic rd_until(input int want);
    int n, k;
    n = 0;
    k = 0;
    while (n < want && k < 40) begin
      @(negedge clk);
      k++;
      if (RD_ACK) n++;
      step();
    end
    check("rd_until", n, want);
  endtask

  task automatic writer_proc();
    for (int i = 0; i < NW; i++) begin
      int g, k;
      g = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      if (g != 0) begin
        WR_REQ = 1'b0;
        repeat (g) step();
      end
      WR_ADDR = AW'($urandom);
      WR_DATA = $urandom;
      WR_BE   = 4'($urandom);
      WR_REQ  = 1'b1;
      wq.push_back({WR_ADDR, WR_DATA, WR_BE});
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!WR_ACK && k < 1000);
      check("wr_handshake", {63'd0, WR_ACK}, 64'd1);
      step();
    end
    WR_REQ = 1'b0;
  endtask

  task automatic reader_proc();
    for (int i = 0; i < NR; i++) begin
      int g, k;
      g = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : 0;
      if (g != 0) begin
        RD_REQ = 1'b0;
        repeat (g) step();
      end
      RD_ADDR = AW'($urandom);
      RD_REQ  = 1'b1;
      rcq.push_back(RD_ADDR);
      rdq.push_back(rdat(RD_ADDR));
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!RD_ACK && k < 1000);
      check("rd_handshake", {63'd0, RD_ACK}, 64'd1);
      step();
    end
    RD_REQ = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, blk, k;
    logic done;

    // Simultaneous requests: write wins, yields after QN writes.
    do_reset();
    WR_ADDR = 24'h00_1000;
    WR_DATA = 32'hCAFE_0001;
    WR_BE   = 4'hF;
    RD_ADDR = 24'h00_2000;
    WR_REQ  = 1'b1;
    RD_REQ  = 1'b1;
    @(negedge clk);
    check("t1_idle", {61'd0, OWNER, ddr_write}, 64'd0);
    n = 0;
    blk = 0;
    k = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) check("t1_grant", {63'd0, ddr_write}, 64'd1);
      if (ddr_read) done = 1'b1;
      else begin
        if (WR_ACK) n++;
        if (RD_REQ) blk++;
      end
    end
    check("t1_wacks", n, QN);
    check("t1_blocked", blk, QN);
    check("t1_rd_own", {61'd0, done, OWNER}, {61'd0, 1'b1, 2'd2});

    // Stalled write holds command and state.
    do_reset();
    m_wait  = 1'b1;
    WR_ADDR = 24'hA5_5A01;
    WR_DATA = 32'h1234_5678;
    WR_BE   = 4'h5;
    WR_REQ  = 1'b1;
    RD_REQ  = 1'b1;
    @(negedge clk);
    check("t2_idle", {63'd0, ddr_write}, 64'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_stall", {4'd0, ddr_write, ddr_address,
            ddr_writedata, OWNER, WR_ACK},
            {4'd0, 1'b1, 24'hA5_5A01, 32'h1234_5678,
             2'd1, 1'b0});
      step();
    end
    m_wait = 1'b0;
    @(negedge clk);
    check("t2_ack", {61'd0, WR_ACK, OWNER}, {61'd0, 1'b1, 2'd1});
    step();
    WR_REQ = 1'b0;
    step();
    @(negedge clk);
    check("t2_to_rd", {62'd0, OWNER}, 64'd2);

    // Read cap, then drain before handing over to the writer.
    do_reset();
    RD_ADDR = 24'h00_0300;
    RD_REQ  = 1'b1;
    count_rd(12, n);
    check("t3_cap_acks", n, MO);
    @(negedge clk);
    check("t3_blocked", {61'd0, ddr_read, OWNER},
          {61'd0, 1'b0, 2'd2});
    step();
    WR_REQ = 1'b1;
    step();
    @(negedge clk);
    check("t3_drain", {61'd0, OWNER, ddr_write},
          {61'd0, 2'd3, 1'b0});
    for (int i = 1; i <= MO; i++) begin
      step();
      m_valid = 1'b1;
      m_data  = 32'(i);
      @(negedge clk);
      check("t3_pulse", {29'd0, RD_VALID, OWNER, RD_DATA},
            {29'd0, 1'b1, 2'd3, 32'(i)});
    end
    step();
    m_valid = 1'b0;
    @(negedge clk);
    check("t3_wr_own", {61'd0, OWNER, ddr_write},
          {61'd0, 2'd1, 1'b1});

    // Ack and return in the same cycle leave the count alone.
    do_reset();
    RD_ADDR = 24'h00_0400;
    RD_REQ  = 1'b1;
    rd_until(3);
    m_valid = 1'b1;
    @(negedge clk);
    check("t4_both", {62'd0, RD_ACK, RD_VALID}, 64'd3);
    step();
    m_valid = 1'b0;
    count_rd(12, n);
    check("t4_remaining", n, MO - 3);

    // Reset during a stalled read with 4 in flight.
    do_reset();
    RD_ADDR = 24'h00_0500;
    RD_REQ  = 1'b1;
    rd_until(4);
    m_wait = 1'b1;
    @(negedge clk);
    check("t5_stalled", {60'd0, ddr_read, RD_ACK, OWNER},
          {60'd0, 1'b1, 1'b0, 2'd2});
    step();
    SYS_RESET = 1'b1;
    @(negedge clk);
    check("t5_rst", {59'd0, OWNER, ddr_read, ddr_write, RD_ACK},
          64'd0);
    step();
    SYS_RESET = 1'b0;
    RD_REQ  = 1'b0;
    m_wait  = 1'b0;
    m_valid = 1'b1;
    m_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t5_stray", {31'd0, RD_VALID, RD_DATA},
          {31'd0, 1'b1, 32'hDEAD_BEEF});
    step();
    m_valid = 1'b0;
    RD_REQ  = 1'b1;
    count_rd(12, n);
    check("t5_count_zero", n, MO);

    // Randomized traffic against the scoreboard.
    do_reset();
    auto_ddr = 1'b1;
    mon_en   = 1'b1;
    fork
      writer_proc();
      reader_proc();
    join
    k = 0;
    while (rdq.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("drain_rd", rdq.size(), 0);
    check("drain_rc", rcq.size(), 0);
    check("drain_wr", wq.size(), 0);
    @(negedge clk);
`ifdef TS_DDR_ARB_STATS_EN
    check("wr_count", {32'd0, WR_COUNT}, NW);
    check("rd_count", {32'd0, RD_COUNT}, NR);
`else
    check("wr_count", {32'd0, WR_COUNT}, 0);
    check("rd_count", {32'd0, RD_COUNT}, 0);
`endif
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
